// File: rtl/muldiv_pkg.sv
// Shared types and operation decode helpers for the RV32M/RV64M multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } muldiv_state_e;

  // funct3 bit 2 separates the divide group from the multiply group
  function automatic logic is_div_op(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic is_signed_a(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_signed_b(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response channel between the execute stage and the multiply/divide unit.
interface muldiv_if #(parameter int XLEN = 32);

  logic            req_valid_i;
  logic            req_ready_o;
  logic [2:0]      req_op_i;
  logic [XLEN-1:0] req_a_i;
  logic [XLEN-1:0] req_b_i;
  logic            flush_i;
  logic            resp_valid_o;
  logic            resp_ready_i;
  logic [XLEN-1:0] resp_data_o;

  modport master (
    output req_valid_i, req_op_i, req_a_i, req_b_i, flush_i, resp_ready_i,
    input  req_ready_o, resp_valid_o, resp_data_o
  );

  modport slave (
    input  req_valid_i, req_op_i, req_a_i, req_b_i, flush_i, resp_ready_i,
    output req_ready_o, resp_valid_o, resp_data_o
  );

endinterface

// File: rtl/muldiv_div_core.sv
// Iterative radix-2 restoring divider on unsigned magnitudes; one quotient bit per cycle.
module muldiv_div_core #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            kill,
  input  logic            start,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done,
  output logic [XLEN-1:0] quo,
  output logic [XLEN-1:0] rem
);

  localparam int CNT_W = $clog2(XLEN + 1);

  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  dvs;
  logic [XLEN:0]    trial;

  // Trial subtraction of the divisor from the partial remainder shifted left by one
  always_comb begin
    trial = {rem, quo[XLEN-1]} - {1'b0, dvs};
  end

  // Iteration counter; done pulses for one cycle after the final step
  always_ff @(posedge clk) begin
    if (rst || kill) begin
      cnt  <= '0;
      done <= 1'b0;
    end else if (start) begin
      cnt  <= CNT_W'(XLEN);
      done <= 1'b0;
    end else if (cnt != '0) begin
      cnt  <= cnt - 1'b1;
      done <= (cnt == CNT_W'(1));
    end else begin
      done <= 1'b0;
    end
  end

  // Operand load, then one restoring step per active iteration
  always_ff @(posedge clk) begin
    if (start) begin
      rem <= '0;
      quo <= dividend;
      dvs <= divisor;
    end else if (cnt != '0) begin
      if (!trial[XLEN]) begin
        rem <= trial[XLEN-1:0];
        quo <= {quo[XLEN-2:0], 1'b1};
      end else begin
        rem <= {rem[XLEN-2:0], quo[XLEN-1]};
        quo <= {quo[XLEN-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M/RV64M multiply/divide unit: fixed-latency multiply, iterative divide
// with single-cycle fast paths for divide-by-zero and signed overflow.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 2
) (
  input logic     clk,
  input logic     rst,
  muldiv_if.slave bus
);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_MUL  = ST_MUL;
  localparam logic [1:0] S_DIV  = ST_DIV;
  localparam logic [1:0] S_DONE = ST_DONE;

  localparam int MC_W = (MUL_LAT > 1) ? $clog2(MUL_LAT + 1) : 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]      state;
  logic [MC_W-1:0] mul_cnt;
  logic [XLEN-1:0] resp_data;
  logic [2:0]      op_q;
  logic [XLEN-1:0] a_q, b_q;
  logic            neg_q, neg_r;

  logic [2:0]      req_op;
  logic [XLEN-1:0] req_a, req_b;
  logic            accept, sa, sb, b_zero, ovf, fast, div_start;
  logic [XLEN-1:0] fast_res, abs_a, abs_b, fixup_res;
  logic            div_done;
  logic [XLEN-1:0] div_quo, div_rem;

  // Operands are widened to 2*XLEN with the per-op sign rule; the low 2*XLEN
  // product bits are exact modulo 2^(2*XLEN), which is all that is selected.
  function automatic logic [XLEN-1:0] mul_result(input logic [2:0] op,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
    logic signed [2*XLEN-1:0] a_x, b_x, p;
    a_x = $signed({{XLEN{is_signed_a(op) & a[XLEN-1]}}, a});
    b_x = $signed({{XLEN{is_signed_b(op) & b[XLEN-1]}}, b});
    p   = a_x * b_x;
    return (op == OP_MUL) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  assign req_op = bus.req_op_i;
  assign req_a  = bus.req_a_i;
  assign req_b  = bus.req_b_i;

  assign bus.req_ready_o  = (state == S_IDLE) && !bus.flush_i;
  assign bus.resp_valid_o = (state == S_DONE);
  assign bus.resp_data_o  = resp_data;

  // Accept decode, fast-path detection and divider operand magnitudes
  always_comb begin
    accept    = (state == S_IDLE) && bus.req_valid_i && !bus.flush_i;
    sa        = is_signed_a(req_op) & req_a[XLEN-1];
    sb        = is_signed_b(req_op) & req_b[XLEN-1];
    b_zero    = (req_b == '0);
    ovf       = is_signed_a(req_op) && (req_a == MIN_NEG) && (req_b == '1);
    fast      = is_div_op(req_op) && (b_zero || ovf);
    fast_res  = b_zero ? (req_op[1] ? req_a : '1) : (req_op[1] ? '0 : req_a);
    abs_a     = sa ? -req_a : req_a;
    abs_b     = sb ? -req_b : req_b;
    div_start = accept && is_div_op(req_op) && !fast;
  end

  // Sign fixup of the unsigned divider result; op bit 1 selects remainder
  always_comb begin
    if (op_q[1]) fixup_res = neg_r ? -div_rem : div_rem;
    else         fixup_res = neg_q ? -div_quo : div_quo;
  end

  muldiv_div_core #(.XLEN(XLEN)) u_div (
    .clk      (clk),
    .rst      (rst),
    .kill     (bus.flush_i),
    .start    (div_start),
    .dividend (abs_a),
    .divisor  (abs_b),
    .done     (div_done),
    .quo      (div_quo),
    .rem      (div_rem)
  );

  // Operand capture on accept (data only, no reset needed)
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q  <= req_op;
      a_q   <= req_a;
      b_q   <= req_b;
      neg_q <= sa ^ sb;
      neg_r <= sa;
    end
  end

  // Control FSM and registered result; reset beats flush
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      mul_cnt   <= '0;
      resp_data <= '0;
    end else if (bus.flush_i) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (!is_div_op(req_op)) begin
              if (MUL_LAT == 1) begin
                state     <= S_DONE;
                resp_data <= mul_result(req_op, req_a, req_b);
              end else begin
                state   <= S_MUL;
                mul_cnt <= MC_W'(MUL_LAT - 1);
              end
            end else if (fast) begin
              state     <= S_DONE;
              resp_data <= fast_res;
            end else begin
              state <= S_DIV;
            end
          end
        end
        S_MUL: begin
          if (mul_cnt == MC_W'(1)) begin
            state     <= S_DONE;
            mul_cnt   <= '0;
            resp_data <= mul_result(op_q, a_q, b_q);
          end else begin
            mul_cnt <= mul_cnt - 1'b1;
          end
        end
        S_DIV: begin
          if (div_done) begin
            state     <= S_DONE;
            resp_data <= fixup_res;
          end
        end
        S_DONE: begin
          if (bus.resp_ready_i) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: reference results from plain RISC-V M-extension arithmetic.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int XLEN    = 32;
  localparam int MUL_LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rr_mode = 0;

  muldiv_if #(.XLEN(XLEN)) bus ();

  muldiv_unit #(.XLEN(XLEN), .MUL_LAT(MUL_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] data;
    int          lat;
    int          t0;
  } exp_t;

  exp_t sbq[$];

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } vec_t;

  vec_t dir_vec [14] = '{
    '{3'd1, 32'hFFFFFFF9, 32'd3},
    '{3'd0, 32'hFFFFFFF9, 32'd3},
    '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF},
    '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF},
    '{3'd4, 32'hFFFFFFEC, 32'd3},
    '{3'd6, 32'hFFFFFFEC, 32'd3},
    '{3'd5, 32'd20, 32'd3},
    '{3'd4, 32'd5, 32'd0},
    '{3'd7, 32'd5, 32'd0},
    '{3'd4, 32'h80000000, 32'hFFFFFFFF},
    '{3'd6, 32'h80000000, 32'hFFFFFFFF},
    '{3'd5, 32'h80000000, 32'hFFFFFFFF},
    '{3'd6, 32'd17, 32'd0},
    '{3'd7, 32'hFFFFFFFF, 32'd10}
  };

  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint av, bv, p;
    logic   ovf;
    ovf = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
    case (op)
      3'd0, 3'd1, 3'd2, 3'd3: begin
        av = (op == 3'd1 || op == 3'd2) ? longint'($signed(a)) : longint'(a);
        bv = (op == 3'd1) ? longint'($signed(b)) : longint'(b);
        p  = av * bv;
        return (op == 3'd0) ? p[31:0] : p[63:32];
      end
      3'd4: return (b == 0) ? 32'hFFFFFFFF : ovf ? a : 32'($signed(a) / $signed(b));
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    if (op < 3'd4) return MUL_LAT;
    if (b == 0) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
    return XLEN + 2;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Issue one request once the unit is ready; optionally expect a response
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit push);
    exp_t e;
    int   w;
    w = 0;
    @(negedge clk);
    while (!bus.req_ready_o && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!bus.req_ready_o) begin
      chk("req_ready_timeout", 32'(bus.req_ready_o), 32'd1);
      return;
    end
    bus.req_valid_i = 1'b1;
    bus.req_op_i    = op;
    bus.req_a_i     = a;
    bus.req_b_i     = b;
    if (push) begin
      e.op   = op;
      e.data = ref_result(op, a, b);
      e.lat  = ref_latency(op, a, b);
      e.t0   = cyc;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.req_valid_i = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300 && sbq.size() != 0; i++) @(negedge clk);
    chk("drain_pending", 32'(sbq.size()), 32'd0);
    sbq.delete();
  endtask

  // Response ready pattern, changed just after each rising edge
  initial begin
    bus.resp_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rr_mode)
        0: bus.resp_ready_i = 1'b1;
        1: bus.resp_ready_i = ($urandom_range(0, 3) != 0);
        default: bus.resp_ready_i = 1'b0;
      endcase
    end
  end

  // Monitor: latency, stability under stall, and result check on each handshake
  logic        prev_valid = 1'b0;
  logic [31:0] prev_data  = '0;
  logic        chk_ready_next = 1'b0;
  exp_t        got;

  always @(negedge clk) begin
    if (rst) begin
      prev_valid     = 1'b0;
      chk_ready_next = 1'b0;
    end else begin
      if (chk_ready_next) begin
        chk("ready_after_handshake", 32'(bus.req_ready_o), 32'd1);
        chk_ready_next = 1'b0;
      end
      if (bus.resp_valid_o) begin
        chk("req_ready_while_valid", 32'(bus.req_ready_o), 32'd0);
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: got valid data %h expected no response", bus.resp_data_o);
        end else begin
          if (!prev_valid)
            chk($sformatf("latency_op%0d", sbq[0].op), 32'(cyc - sbq[0].t0), 32'(sbq[0].lat));
          else
            chk("data_stable", bus.resp_data_o, prev_data);
          if (bus.resp_ready_i) begin
            got = sbq.pop_front();
            chk($sformatf("result_op%0d", got.op), bus.resp_data_o, got.data);
            chk_ready_next = 1'b1;
          end
        end
        prev_valid = !bus.resp_ready_i;
        prev_data  = bus.resp_data_o;
      end else begin
        prev_valid = 1'b0;
      end
    end
  end

  // Global bound on run time
  initial begin
    #1000000;
    errors++;
    $display("FAIL global_timeout: got no finish expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Stimulus
  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    int          sel, w;

    bus.req_valid_i = 1'b0;
    bus.req_op_i    = '0;
    bus.req_a_i     = '0;
    bus.req_b_i     = '0;
    bus.flush_i     = 1'b0;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_req_ready", 32'(bus.req_ready_o), 32'd1);
    chk("reset_resp_valid", 32'(bus.resp_valid_o), 32'd0);
    chk("reset_resp_data", bus.resp_data_o, 32'd0);

    // Directed vectors from the plan plus corner cases
    foreach (dir_vec[i]) issue(dir_vec[i].op, dir_vec[i].a, dir_vec[i].b, 1'b1);
    wait_drain();

    // Response backpressure: hold ready low for 10 cycles after valid
    rr_mode = 2;
    issue(3'd5, 32'd100, 32'd7, 1'b1);
    w = 0;
    while (!bus.resp_valid_o && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("stall_valid_seen", 32'(bus.resp_valid_o), 32'd1);
    repeat (10) @(negedge clk);
    rr_mode = 0;
    issue(3'd0, 32'd12345, 32'd678, 1'b1);
    wait_drain();

    // Flush at divide iteration 10: nothing may come back
    issue(3'd4, 32'h7654321, 32'd7, 1'b0);
    repeat (9) @(posedge clk);
    #1 bus.flush_i = 1'b1;
    @(posedge clk);
    #1 bus.flush_i = 1'b0;
    @(negedge clk);
    chk("flush_idle_ready", 32'(bus.req_ready_o), 32'd1);
    chk("flush_no_valid", 32'(bus.resp_valid_o), 32'd0);
    repeat (40) @(negedge clk);

    // Flush together with a request in IDLE: request must be refused
    bus.req_valid_i = 1'b1;
    bus.req_op_i    = 3'd0;
    bus.req_a_i     = 32'd3;
    bus.req_b_i     = 32'd4;
    bus.flush_i     = 1'b1;
    #1;
    chk("flush_gates_ready", 32'(bus.req_ready_o), 32'd0);
    @(posedge clk);
    #1;
    bus.req_valid_i = 1'b0;
    bus.flush_i     = 1'b0;
    repeat (5) @(negedge clk);
    chk("flush_req_dropped", 32'(bus.req_ready_o), 32'd1);

    // Reset in the middle of a multiply
    issue(3'd0, 32'd9, 32'd9, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midmul_rst_ready", 32'(bus.req_ready_o), 32'd1);
    chk("midmul_rst_valid", 32'(bus.resp_valid_o), 32'd0);
    chk("midmul_rst_data", bus.resp_data_o, 32'd0);
    issue(3'd1, 32'h80000000, 32'h80000000, 1'b1);
    wait_drain();

    // Randomized operations with random response backpressure
    rr_mode = 1;
    for (int n = 0; n < 150; n++) begin
      op  = 3'($urandom_range(0, 7));
      sel = $urandom_range(0, 9);
      a   = $urandom();
      b   = $urandom();
      case (sel)
        0: b = 32'd0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: a = 32'($urandom_range(0, 255));
        default: ;
      endcase
      issue(op, a, b, 1'b1);
    end
    wait_drain();
    rr_mode = 0;

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised multi-cycle multiply/divide unit implementing the full RV32M/RV64M operation set (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU). It sits beside the single-cycle ALU in the execute stage. The core issues one operation through a valid/ready request channel and stalls until the result returns on a valid/ready response channel. Multiply uses a configurable fixed latency; divide uses an iterative radix-2 restoring divider with single-cycle fast paths for divide-by-zero and signed overflow.

## Interface
- XLEN, 32: operand and result width; legal values 32 or 64.
- MUL_LAT, 2: cycles from request accept to response valid for multiply ops; must be at least 1.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  unit can accept a request; high only in IDLE.
- req_op_i  in  3  operation, RISC-V funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- req_a_i  in  XLEN  rs1 operand.
- req_b_i  in  XLEN  rs2 operand.
- flush_i  in  1  kill any in-flight operation and return to IDLE.
- resp_valid_o  out  1  result available.
- resp_ready_i  in  1  consumer takes result.
- resp_data_o  out  XLEN  result; holds its value while resp_valid_o is high.

## Operation
- States: IDLE, MUL, DIV, DONE.
- **IDLE**
  - req_ready_o=1.
  - On accept (req_valid_i && req_ready_o), latch op, a and b.
  - Op 0–3 go to MUL; op 4–7 go to DIV.
  - Exception: a DIV/REM op with b==0 or signed overflow goes directly to DONE with the result precomputed.
- **MUL**
  - Operands are sign-extended to XLEN+1 bits.
  - a is signed for MULH and MULHSU; b is signed only for MULH.
  - The 2·XLEN-bit product is computed and held.
  - A down-counter loaded with MUL_LAT−1 on accept counts to 0, then the state goes to DONE.
  - MUL selects product[XLEN-1:0]; the other multiply ops select product[2·XLEN-1:XLEN].
- **DIV**
  - Signed ops (DIV, REM) take operand magnitudes; quotient sign = a_sign XOR b_sign; remainder sign = a_sign.
  - Each cycle performs one restoring step: shift {rem,quo} left, trial-subtract |b|, set quotient bit.
  - The iteration counter runs XLEN cycles.
  - One additional fixup cycle negates quotient and/or remainder as required, then the state goes to DONE.
- **DONE**
  - resp_valid_o=1.
  - Leaves to IDLE when resp_ready_i=1.
  - No new request is accepted in the same cycle, so there is no back-to-back overlap.
- **Divide by zero:** quotient = all ones (DIV and DIVU); remainder = a.
- **Signed overflow** (a = −2^(XLEN−1), b = −1, DIV/REM only): quotient = a, remainder = 0.
- **Flush**
  - flush_i in any state forces IDLE next cycle and clears resp_valid_o; the result is discarded.
  - flush_i together with a request in IDLE: the request is not accepted, so req_ready_o is gated by !flush_i.
- **Reset** (any state, including mid-divide):
  - state=IDLE, resp_valid_o=0, resp_data_o=0, counters=0.
  - req_ready_o=1 from the first cycle after reset deasserts.
  - rst has priority over flush_i.

## Timing
- Let accept be the edge ending cycle N.
- Multiply: resp_valid_o first high in cycle N+MUL_LAT.
- Normal divide: resp_valid_o first high in cycle N+XLEN+2 (XLEN iterations, one fixup cycle, registered DONE).
- Divide fast path (b==0 or overflow): resp_valid_o high in cycle N+1.
- Response backpressure: DONE holds indefinitely; resp_data_o stays stable.
- Next accept: the earliest is the cycle after the resp handshake.
- All outputs are registered; there is no combinational path from req_*_i to resp_*_o.

## Structure
- Package `muldiv_pkg`:
  - `muldiv_op_e` enum (funct3 values).
  - `muldiv_state_e` enum (IDLE, MUL, DIV, DONE).
  - Helper functions `is_div_op`, `is_signed_a`, `is_signed_b`.
- Sub-module `muldiv_div_core`:
  - Holds the iterative restoring divider: rem/quo/divisor registers, iteration counter and step datapath.
  - Start and done strobes.
  - XLEN parameter.
- Multiply, fast-path detection, sign fixup selection and the FSM stay in `muldiv_unit`.

## Test plan
- MULH a=−7 (0xFFFFFFF9), b=3, XLEN=32 → resp_data=0xFFFFFFFF, valid at N+2; MUL on same operands → 0xFFFFFFEB.
- MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF → 0xFFFFFFFF; MULHU on same operands → 0xFFFFFFFE.
- DIV a=−20, b=3 → −6 (0xFFFFFFFA) at N+34; REM on same operands → −2; DIVU a=20, b=3 → 6.
- DIV a=5, b=0 → 0xFFFFFFFF at N+1; REMU a=5, b=0 → 5; DIV a=0x80000000, b=−1 → 0x80000000; REM on same operands → 0.
- Response stall: hold resp_ready_i=0 for 10 cycles after valid → resp_valid and data stable, req_ready_o=0; release → IDLE next cycle, new accept possible.
- flush_i at iteration 10 of a DIV → IDLE next cycle, no resp_valid ever; rst mid-MUL → all outputs at reset values, next op correct.
